// File: rtl/serial_adder_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_ctrl_pkg
// Description : Shared state encodings and counter sizing helper for the
//               bit-serial adder controller.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_ctrl_pkg;

   // Controller states; the unused code 2'b11 falls back to ST_IDLE
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ADD  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   // Bit-counter width: ceil(log2 n), never narrower than one bit
   function automatic int cnt_width(input int n);
      int w;
      w = $clog2(n);
      if (w < 1) begin
         w = 1;
      end
      return w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/serial_adder_ctrl_full_adder_bit.sv
`default_nettype none
// ============================================================================
// Module      : full_adder_bit
// Description : One-bit combinational full adder (sum and majority carry).
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder_bit (
   input  logic x,
   input  logic y,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = x ^ y ^ cin;
   assign cout = (x & y) | (x & cin) | (y & cin);

endmodule
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_ctrl
// Description : Bit-serial adder controller. Loads two N-bit operands on
//               start, adds one bit pair per clock LSB first through a
//               single full-adder cell, and pulses done when finished.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_ctrl #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] a_in,
   input  logic [N-1:0] b_in,
   output logic [N-1:0] sum,
   output logic         cout,
   output logic         busy,
   output logic         done
);

   import serial_adder_ctrl_pkg::*;

   localparam int CW = cnt_width(N);

   state_t          r_state;
   logic [N-1:0]    r_ra;
   logic [N-1:0]    r_rb;
   logic [N-1:0]    r_rs;
   logic            r_c;
   logic [CW-1:0]   r_cnt;
   logic            r_busy;
   logic            r_done;

   logic            w_fa_s;
   logic            w_fa_c;
   logic [N-1:0]    w_rs_next;

   full_adder_bit u_fa (
      .x    (r_ra[0]),
      .y    (r_rb[0]),
      .cin  (r_c),
      .s    (w_fa_s),
      .cout (w_fa_c)
   );

   // Result register shifts right with the new sum bit entering at the MSB
   always_comb begin
      w_rs_next        = r_rs >> 1;
      w_rs_next[N-1]   = w_fa_s;
   end

   // Controller FSM with operand/result shift registers and bit counter.
   // The DONE cycle may accept a new start so that a held start yields one
   // operation every N+1 cycles; the result still holds until that load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_ra    <= '0;
         r_rb    <= '0;
         r_rs    <= '0;
         r_c     <= 1'b0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_ra    <= a_in;
                  r_rb    <= b_in;
                  r_rs    <= '0;
                  r_c     <= 1'b0;
                  r_cnt   <= CW'(N - 1);
                  r_busy  <= 1'b1;
                  r_state <= ST_ADD;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_ADD: begin
               r_rs <= w_rs_next;
               r_ra <= r_ra >> 1;
               r_rb <= r_rb >> 1;
               r_c  <= w_fa_c;
               if (r_cnt == '0) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign sum  = r_rs;
   assign cout = r_c;
   assign busy = r_busy;
   assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder_ctrl
// Description : Scoreboard bench for serial_adder_ctrl at N=8 and N=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start8, start1;
   logic [7:0] a8, b8, sum8;
   logic       a1, b1, sum1;
   logic       cout8, busy8, done8;
   logic       cout1, busy1, done1;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int busy_run8 = 0, busy_run1 = 0;
   int done_cnt8 = 0, done_cnt1 = 0;
   logic [8:0] q8[$];
   logic [1:0] q1[$];
   int done_t8[$];

   serial_adder_ctrl #(.N(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a_in(a8), .b_in(b8),
      .sum(sum8), .cout(cout8), .busy(busy8), .done(done8)
   );

   serial_adder_ctrl #(.N(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a_in(a1), .b_in(b1),
      .sum(sum1), .cout(cout1), .busy(busy1), .done(done1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Scoreboard for the N=8 instance
   always @(negedge clk) begin
      logic [8:0] e;
      if (!rst_n) begin
         busy_run8 = 0;
      end else begin
         if (busy8) busy_run8++;
         if (done8) begin
            done_cnt8++;
            done_t8.push_back(cyc);
            check("busy_len8", busy_run8, 8);
            check("busy_at_done8", busy8, 0);
            busy_run8 = 0;
            if (q8.size() == 0) check("unexpected_done8", 1, 0);
            else begin
               e = q8.pop_front();
               check("sum8", sum8, e[7:0]);
               check("cout8", cout8, e[8]);
            end
         end
      end
   end

   // Scoreboard for the N=1 instance
   always @(negedge clk) begin
      logic [1:0] e;
      if (!rst_n) begin
         busy_run1 = 0;
      end else begin
         if (busy1) busy_run1++;
         if (done1) begin
            done_cnt1++;
            check("busy_len1", busy_run1, 1);
            busy_run1 = 0;
            if (q1.size() == 0) check("unexpected_done1", 1, 0);
            else begin
               e = q1.pop_front();
               check("sum1", sum1, e[0]);
               check("cout1", cout1, e[1]);
            end
         end
      end
   end

   // Launch one N=8 addition; caller is #1 after an edge with the DUT idle
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit push);
      start8 = 1'b1; a8 = a; b8 = b;
      if (push) q8.push_back({1'b0, a} + {1'b0, b});
      @(posedge clk); #1;
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
   endtask

   task automatic op1(input logic a, input logic b);
      start1 = 1'b1; a1 = a; b1 = b;
      q1.push_back({1'b0, a} + {1'b0, b});
      @(posedge clk); #1;
      start1 = 1'b0; a1 = ~a; b1 = ~b;
   endtask

   task automatic wait_done8();
      int n = 0;
      do begin @(negedge clk); n++; end while (!done8 && n < 40);
      if (!done8) check("timeout8", 0, 1);
      @(posedge clk); #1;
   endtask

   task automatic wait_done1();
      int n = 0;
      do begin @(negedge clk); n++; end while (!done1 && n < 10);
      if (!done1) check("timeout1", 0, 1);
      @(posedge clk); #1;
   endtask

   initial begin
      int dc;
      rst_n = 1'b0; start8 = 1'b0; start1 = 1'b0;
      a8 = '0; b8 = '0; a1 = 1'b0; b1 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_sum8",  sum8,  0);
      check("rst_cout8", cout8, 0);
      check("rst_busy8", busy8, 0);
      check("rst_done8", done8, 0);
      check("rst_sum1",  sum1,  0);
      check("rst_busy1", busy1, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic additions, including carry-out and no carry leakage between ops
      op8(8'h5A, 8'h3C, 1'b1); wait_done8();
      op8(8'hFF, 8'h01, 1'b1); wait_done8();
      op8(8'hFF, 8'hFF, 1'b1); wait_done8();
      check("hold_sum8",  sum8,  8'hFE);
      check("hold_cout8", cout8, 1);

      // Start during ADD must be ignored
      dc = done_cnt8;
      op8(8'h10, 8'h20, 1'b1);
      repeat (2) @(posedge clk);
      #1; start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
      @(posedge clk); #1; start8 = 1'b0;
      wait_done8();
      repeat (12) @(posedge clk);
      #1;
      check("one_done8", done_cnt8 - dc, 1);

      // Asynchronous reset in the middle of ADD
      dc = done_cnt8;
      op8(8'hAA, 8'h55, 1'b0);
      repeat (4) @(posedge clk);
      #3; rst_n = 1'b0;
      #1;
      check("mid_rst_sum8",  sum8,  0);
      check("mid_rst_cout8", cout8, 0);
      check("mid_rst_busy8", busy8, 0);
      check("mid_rst_done8", done8, 0);
      @(posedge clk); @(posedge clk);
      #2; rst_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      check("no_done_after_rst8", done_cnt8 - dc, 0);
      op8(8'h01, 8'h02, 1'b1); wait_done8();

      // Start held high: one launch every 9 cycles
      done_t8.delete();
      start8 = 1'b1; a8 = 8'h7F; b8 = 8'h01;
      repeat (4) q8.push_back(9'h080);
      repeat (30) @(posedge clk);
      #1; start8 = 1'b0;
      wait_done8();
      check("stream_dones8", done_t8.size(), 4);
      for (int i = 1; i < done_t8.size(); i++)
         check("stream_gap8", done_t8[i] - done_t8[i-1], 9);
      check("q8_empty", q8.size(), 0);

      // Single-bit instance
      op1(1'b1, 1'b1); wait_done1();
      op1(1'b0, 1'b1); wait_done1();
      check("q1_empty", q1.size(), 0);
      check("done_cnt1", done_cnt1, 2);

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
